ddr3_burst_sequencer: RTL and testbench

DDR3_BURST_SEQUENCER -- requirements
Module: ddr3_burst_sequencer

---
 rtl/ddr3_pkg.sv | 14 +
 rtl/ddr3_burst_counter.sv | 37 +++
 rtl/ddr3_burst_sequencer.sv | 142 ++++++++++++++
 tb/tb_ddr3_burst_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared types and default geometry for the DDR3 burst sequencer.
package ddr3_pkg;

    localparam int unsigned ADDR_W_DEF   = 26;
    localparam int unsigned CNT_W_DEF    = 23;
    localparam int unsigned ADDR_INC_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ddr3_burst_counter.sv
// Burst address/count pair: loads on start, steps by one burst per accepted ack.
module ddr3_burst_counter #(
    parameter int unsigned ADDR_W   = 26,
    parameter int unsigned CNT_W    = 23,
    parameter int unsigned ADDR_INC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              zero,
    output logic              last
);

    logic [CNT_W-1:0] cnt;

    // Address wraps naturally at 2^ADDR_W; count never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= load_addr;
            cnt  <= load_cnt;
        end else if (step && !zero) begin
            addr <= addr + ADDR_W'(ADDR_INC);
            cnt  <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/ddr3_burst_sequencer.sv
// Sequences BL8 write bursts (ADC FIFO -> DDR3) or read bursts (DDR3 -> readout FIFO),
// one direction at a time.
module ddr3_burst_sequencer
    import ddr3_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned ADDR_INC = ADDR_INC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_start_addr,
    input  logic [CNT_W-1:0]  wr_burst_cnt,
    input  logic              wr_data_avail,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_start_addr,
    input  logic [CNT_W-1:0]  rd_burst_cnt,
    input  logic              rd_space_avail,
    output logic              wr_mode,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_request,
    input  logic              wr_addr_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_request,
    input  logic              rd_addr_ack,
    output logic              wr_done,
    output logic              rd_done,
    output logic              busy,
    output logic              start_err
);

    seq_state_t state, state_next;
    logic wr_load, rd_load;
    logic wr_step, rd_step;
    logic wr_zero, rd_zero;
    logic wr_last, rd_last;
    logic wr_done_next, rd_done_next, start_err_next;

    ddr3_burst_counter #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .ADDR_INC (ADDR_INC)
    ) u_wr_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (wr_load),
        .load_addr (wr_start_addr),
        .load_cnt  (wr_burst_cnt),
        .step      (wr_step),
        .addr      (wr_addr),
        .zero      (wr_zero),
        .last      (wr_last)
    );

    ddr3_burst_counter #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .ADDR_INC (ADDR_INC)
    ) u_rd_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_load),
        .load_addr (rd_start_addr),
        .load_cnt  (rd_burst_cnt),
        .step      (rd_step),
        .addr      (rd_addr),
        .zero      (rd_zero),
        .last      (rd_last)
    );

    assign wr_mode    = (state == ST_WRITE);
    assign wr_request = wr_mode && wr_data_avail;
    assign rd_request = (state == ST_READ) && rd_space_avail;
    assign wr_step    = wr_request && wr_addr_ack;
    assign rd_step    = rd_request && rd_addr_ack;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_next;
            wr_done   <= wr_done_next;
            rd_done   <= rd_done_next;
            start_err <= start_err_next;
        end
    end

    // Write wins a simultaneous start; a zero-count start completes without leaving IDLE.
    always_comb begin
        state_next     = state;
        wr_load        = 1'b0;
        rd_load        = 1'b0;
        wr_done_next   = 1'b0;
        rd_done_next   = 1'b0;
        start_err_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_start) begin
                    if (wr_burst_cnt != '0) begin
                        wr_load    = 1'b1;
                        state_next = ST_WRITE;
                    end else begin
                        wr_done_next = 1'b1;
                    end
                    start_err_next = rd_start;
                end else if (rd_start) begin
                    if (rd_burst_cnt != '0) begin
                        rd_load    = 1'b1;
                        state_next = ST_READ;
                    end else begin
                        rd_done_next = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                start_err_next = wr_start || rd_start;
                if (wr_step && wr_last) begin
                    state_next   = ST_IDLE;
                    wr_done_next = 1'b1;
                end else if (wr_zero) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                start_err_next = wr_start || rd_start;
                if (rd_step && rd_last) begin
                    state_next   = ST_IDLE;
                    rd_done_next = 1'b1;
                end else if (rd_zero) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr3_burst_sequencer.sv
// Scoreboard bench: stimulus queues expected addresses and pulses, a negedge monitor checks them.
module tb_ddr3_burst_sequencer;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned CNT_W  = 23;

    logic              clk;
    logic              rst;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_start_addr;
    logic [CNT_W-1:0]  wr_burst_cnt;
    logic              wr_data_avail;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_start_addr;
    logic [CNT_W-1:0]  rd_burst_cnt;
    logic              rd_space_avail;
    logic              wr_mode;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_request;
    logic              wr_addr_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_request;
    logic              rd_addr_ack;
    logic              wr_done;
    logic              rd_done;
    logic              busy;
    logic              start_err;

    ddr3_burst_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .wr_start       (wr_start),
        .wr_start_addr  (wr_start_addr),
        .wr_burst_cnt   (wr_burst_cnt),
        .wr_data_avail  (wr_data_avail),
        .rd_start       (rd_start),
        .rd_start_addr  (rd_start_addr),
        .rd_burst_cnt   (rd_burst_cnt),
        .rd_space_avail (rd_space_avail),
        .wr_mode        (wr_mode),
        .wr_addr        (wr_addr),
        .wr_request     (wr_request),
        .wr_addr_ack    (wr_addr_ack),
        .rd_addr        (rd_addr),
        .rd_request     (rd_request),
        .rd_addr_ack    (rd_addr_ack),
        .wr_done        (wr_done),
        .rd_done        (rd_done),
        .busy           (busy),
        .start_err      (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    logic [ADDR_W-1:0] wr_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    bit                wr_done_q[$];
    bit                rd_done_q[$];
    bit                err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every issued burst and every pulse must have been predicted.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            checks++;
            if (rd_request && wr_mode) begin
                errors++;
                $display("FAIL excl: rd_request=1 while wr_mode=1");
            end
            if (wr_request && wr_addr_ack) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_issue: unexpected burst addr 0x%0h", wr_addr);
                end else begin
                    logic [ADDR_W-1:0] e;
                    e = wr_q.pop_front();
                    if (wr_addr !== e) begin
                        errors++;
                        $display("FAIL wr_addr: got 0x%0h expected 0x%0h", wr_addr, e);
                    end
                end
            end
            if (rd_request && rd_addr_ack) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_issue: unexpected burst addr 0x%0h", rd_addr);
                end else begin
                    logic [ADDR_W-1:0] e;
                    e = rd_q.pop_front();
                    if (rd_addr !== e) begin
                        errors++;
                        $display("FAIL rd_addr: got 0x%0h expected 0x%0h", rd_addr, e);
                    end
                end
            end
            if (wr_done) begin
                checks++;
                if (wr_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_done: unexpected pulse");
                end else void'(wr_done_q.pop_front());
            end
            if (rd_done) begin
                checks++;
                if (rd_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_done: unexpected pulse");
                end else void'(rd_done_q.pop_front());
            end
            if (start_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL start_err: unexpected pulse");
                end else void'(err_q.pop_front());
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    task automatic drain(input string name);
        check({name, "_wrq"},   32'(wr_q.size()),      32'd0);
        check({name, "_rdq"},   32'(rd_q.size()),      32'd0);
        check({name, "_wrdq"},  32'(wr_done_q.size()), 32'd0);
        check({name, "_rddq"},  32'(rd_done_q.size()), 32'd0);
        check({name, "_errq"},  32'(err_q.size()),     32'd0);
    endtask

    initial begin
        bit space_pat[8];
        space_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        wr_start = 1'b0; wr_start_addr = '0; wr_burst_cnt = '0; wr_data_avail = 1'b0;
        rd_start = 1'b0; rd_start_addr = '0; rd_burst_cnt = '0; rd_space_avail = 1'b0;
        wr_addr_ack = 1'b0; rd_addr_ack = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_wr_mode",   32'(wr_mode),   32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_rd_addr",   32'(rd_addr),   32'd0);
        check("rst_wr_done",   32'(wr_done),   32'd0);
        check("rst_rd_done",   32'(rd_done),   32'd0);
        check("rst_start_err", 32'(start_err), 32'd0);
        check("rst_rd_req",    32'(rd_request), 32'd0);
        tick();
        rst = 1'b0;
        mon_on = 1'b1;

        // Write 3 bursts from 0x100 with ack every cycle.
        wr_q.push_back(26'h100); wr_q.push_back(26'h108); wr_q.push_back(26'h110);
        wr_done_q.push_back(1'b1);
        wr_data_avail = 1'b1; wr_addr_ack = 1'b1;
        wr_start = 1'b1; wr_start_addr = 26'h100; wr_burst_cnt = 23'd3;
        tick();
        wr_start = 1'b0;
        wait_idle("s1");
        drain("s1");

        // Read 2 bursts across the top of the address space.
        rd_q.push_back(26'h3FFFFF8); rd_q.push_back(26'h0000000);
        rd_done_q.push_back(1'b1);
        rd_space_avail = 1'b1; rd_addr_ack = 1'b1;
        rd_start = 1'b1; rd_start_addr = 26'h3FFFFF8; rd_burst_cnt = 23'd2;
        tick();
        rd_start = 1'b0;
        wait_idle("s2");
        drain("s2");

        // Simultaneous starts, then a read start while busy: write only, two rejections.
        wr_q.push_back(26'h200); wr_q.push_back(26'h208);
        wr_done_q.push_back(1'b1);
        err_q.push_back(1'b1); err_q.push_back(1'b1);
        wr_start = 1'b1; wr_start_addr = 26'h200; wr_burst_cnt = 23'd2;
        rd_start = 1'b1; rd_start_addr = 26'h300; rd_burst_cnt = 23'd2;
        tick();
        wr_start = 1'b0;
        tick();
        rd_start = 1'b0;
        wait_idle("s3");
        drain("s3");

        // Zero-count write: done next cycle, never busy.
        wr_done_q.push_back(1'b1);
        wr_start = 1'b1; wr_start_addr = 26'h700; wr_burst_cnt = 23'd0;
        tick();
        wr_start = 1'b0;
        @(negedge clk);
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_done", 32'(wr_done), 32'd1);
        tick();
        drain("s4");

        // Write 4 bursts, reset after two acks: aborted, no done.
        wr_q.push_back(26'h400); wr_q.push_back(26'h408);
        wr_start = 1'b1; wr_start_addr = 26'h400; wr_burst_cnt = 23'd4;
        tick();
        wr_start = 1'b0;
        tick();
        tick();
        rst = 1'b1; wr_addr_ack = 1'b0;
        tick();
        @(negedge clk);
        check("s5_busy",  32'(busy),       32'd0);
        check("s5_wrreq", 32'(wr_request), 32'd0);
        check("s5_wrdone", 32'(wr_done),   32'd0);
        check("s5_wraddr", 32'(wr_addr),   32'd0);
        rst = 1'b0;
        wr_addr_ack = 1'b1;
        tick();
        tick();
        tick();
        drain("s5");

        // Read 3 bursts with space toggling and acks always high.
        rd_q.push_back(26'h500); rd_q.push_back(26'h508); rd_q.push_back(26'h510);
        rd_done_q.push_back(1'b1);
        rd_space_avail = 1'b0; rd_addr_ack = 1'b1;
        rd_start = 1'b1; rd_start_addr = 26'h500; rd_burst_cnt = 23'd3;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_space_avail = space_pat[i];
            tick();
        end
        rd_space_avail = 1'b1;
        wait_idle("s6");
        drain("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
